// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline-control types and constants.
//   state_t  : hazard controller FSM states
//   FWD_*    : EX operand forward-select encodings
//   LD_NONE  : load-type code meaning "not a load"
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [2:0] LD_NONE = 3'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter for performance monitoring.
//   i_clk   : clock, rising edge
//   i_rst_n : async active-low reset, clears the count
//   i_inc   : add one this cycle
//   o_cnt   : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard control (stall/flush/forward + perf counters).
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_id_rs1/2, i_id_use_rs1/2     : ID-stage sources and whether they are read
//   i_ex_rs1/2, i_ex_rd            : EX-stage sources and destination
//   i_ex_read_mem                  : EX load type, nonzero means load
//   i_ex_redirect, i_ex_muldiv     : EX taken branch/jump, EX holds MUL/DIV
//   i_mem_rd/i_wb_rd, *_write_reg  : MEM/WB destinations and writeback enables
//   i_mem_req, i_mem_ready         : data-memory access in MEM, completes this cycle
//   o_*_hold                       : freeze PC / IF/ID / ID/EX / EX/MEM registers
//   o_*_flush                      : insert bubble into IF/ID / ID/EX / MEM/WB
//   o_fwd_rs1/2_sel                : EX operand source (regfile / MEM / WB)
//   o_stall_cnt, o_flush_cnt       : saturating stall and flush cycle counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rs1,
    input  logic [4:0]       i_ex_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic [2:0]       i_ex_read_mem,
    input  logic             i_ex_redirect,
    input  logic             i_ex_muldiv,
    input  logic [4:0]       i_mem_rd,
    input  logic [4:0]       i_wb_rd,
    input  logic             i_mem_write_reg,
    input  logic             i_wb_write_reg,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_hold,
    output logic             o_if_id_hold,
    output logic             o_id_ex_hold,
    output logic             o_ex_mem_hold,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_mem_wb_flush,
    output logic [1:0]       o_fwd_rs1_sel,
    output logic [1:0]       o_fwd_rs2_sel,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    // md_cnt only has to hold MULDIV_LAT-2 (the hold cycles after the entry cycle)
    localparam int MD_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
    localparam logic [MD_W-1:0] MD_INIT = MD_W'(MULDIV_LAT - 2);

    state_t          r_state, w_next;
    logic [MD_W-1:0] r_md_cnt, w_md_next;
    logic            w_load_use, w_mem_busy;
    logic            w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_hold;
    logic            w_if_id_flush, w_id_ex_flush, w_mem_wb_flush;

    assign w_mem_busy = i_mem_req && !i_mem_ready;
    assign w_load_use = (i_ex_read_mem != LD_NONE) && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) ||
                         (i_id_use_rs2 && i_id_rs2 == i_ex_rd));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_md_cnt <= w_md_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_md_next      = r_md_cnt;
        w_pc_hold      = 1'b0;
        w_if_id_hold   = 1'b0;
        w_id_ex_hold   = 1'b0;
        w_ex_mem_hold  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        case (r_state)
            ST_MD_BUSY: begin
                // a memory wait freezes the whole pipe, MUL/DIV progress included
                if (w_mem_busy) begin
                    {w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_hold} = 4'hf;
                    w_mem_wb_flush = 1'b1;
                end else if (r_md_cnt != '0) begin
                    {w_pc_hold, w_if_id_hold, w_id_ex_hold} = 3'b111;
                    w_md_next = r_md_cnt - 1'b1;
                end else begin
                    // release cycle: ex_muldiv is still high for the same op, so ignore it
                    w_next = ST_RUN;
                end
            end
            default: begin
                // RUN and MEM_WAIT share the same rules: the cycle mem_ready arrives
                // is evaluated like RUN, so a pending redirect is acted on here
                w_next = ST_RUN;
                if (w_mem_busy) begin
                    {w_pc_hold, w_if_id_hold, w_id_ex_hold, w_ex_mem_hold} = 4'hf;
                    w_mem_wb_flush = 1'b1;
                    w_next         = ST_MEM_WAIT;
                end else if (i_ex_muldiv) begin
                    {w_pc_hold, w_if_id_hold, w_id_ex_hold} = 3'b111;
                    w_md_next = MD_INIT;
                    w_next    = ST_MD_BUSY;
                end else if (i_ex_redirect) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
        endcase
    end

    // reset drops every hold/flush immediately, without waiting for a clock
    assign o_pc_hold      = w_pc_hold      & i_rst_n;
    assign o_if_id_hold   = w_if_id_hold   & i_rst_n;
    assign o_id_ex_hold   = w_id_ex_hold   & i_rst_n;
    assign o_ex_mem_hold  = w_ex_mem_hold  & i_rst_n;
    assign o_if_id_flush  = w_if_id_flush  & i_rst_n;
    assign o_id_ex_flush  = w_id_ex_flush  & i_rst_n;
    assign o_mem_wb_flush = w_mem_wb_flush & i_rst_n;

    // MEM beats WB; x0 never forwards
    assign o_fwd_rs1_sel = (i_ex_rs1 == 5'd0)                       ? FWD_RF  :
                           (i_mem_write_reg && i_mem_rd == i_ex_rs1) ? FWD_MEM :
                           (i_wb_write_reg  && i_wb_rd  == i_ex_rs1) ? FWD_WB  : FWD_RF;
    assign o_fwd_rs2_sel = (i_ex_rs2 == 5'd0)                       ? FWD_RF  :
                           (i_mem_write_reg && i_mem_rd == i_ex_rs2) ? FWD_MEM :
                           (i_wb_write_reg  && i_wb_rd  == i_ex_rs2) ? FWD_WB  : FWD_RF;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_pc_hold),
        .o_cnt   (o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_if_id_flush | o_id_ex_flush),
        .o_cnt   (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (vector table, directed sequences, random vs model).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic [2:0] ex_read_mem;
    logic id_use_rs1, id_use_rs2, ex_redirect, ex_muldiv;
    logic mem_write_reg, wb_write_reg, mem_req, mem_ready;
    logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd1, fwd2;
    logic [31:0] stall_cnt, flush_cnt;
    logic sat_inc = 1'b0;
    logic [2:0] sat_cnt;
    logic [6:0] ctl;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
        .i_ex_read_mem(ex_read_mem), .i_ex_redirect(ex_redirect), .i_ex_muldiv(ex_muldiv),
        .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
        .i_mem_write_reg(mem_write_reg), .i_wb_write_reg(wb_write_reg),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_hold(pc_hold), .o_if_id_hold(if_id_hold), .o_id_ex_hold(id_ex_hold),
        .o_ex_mem_hold(ex_mem_hold), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_mem_wb_flush(mem_wb_flush), .o_fwd_rs1_sel(fwd1), .o_fwd_rs2_sel(fwd2),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    sat_counter #(.CNT_W(3)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(sat_inc), .o_cnt(sat_cnt)
    );

    assign ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_flush};

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       u1, u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic [2:0] rmem;
        logic       redir;
        logic [4:0] mem_rd, wb_rd;
        logic       mwr, wwr;
        logic [6:0] ctl;
        logic [1:0] f1, f2;
    } vec_t;

    vec_t vt[10];

    int n_pass = 0;
    int n_tot = 0;

    int      m_md_rem;
    bit      m_rel;
    longint  m_stall, m_flush;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        ex_read_mem = '0;
        {id_use_rs1, id_use_rs2, ex_redirect, ex_muldiv} = '0;
        {mem_write_reg, wb_write_reg, mem_req, mem_ready} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        m_md_rem = 0;
        m_rel = 0;
        m_stall = 0;
        m_flush = 0;
        tick();
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_write_reg && mem_rd == rs) return 2'b01;
        if (wb_write_reg && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Pipeline behaviour in terms of "hold cycles still owed" by a MUL/DIV op
    task automatic model_step(output logic [6:0] e);
        bit mb, lu;
        mb = mem_req && !mem_ready;
        lu = (ex_read_mem != 0) && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e = 7'b0;
        if (mb) e = 7'b1111001;
        else begin
            if (m_md_rem == 0 && !m_rel && ex_muldiv) m_md_rem = LAT - 1;
            if (m_md_rem > 0) begin
                e = 7'b1110000;
                m_md_rem--;
                if (m_md_rem == 0) m_rel = 1;
            end else if (m_rel) m_rel = 0;
            else if (ex_redirect) e = 7'b0000110;
            else if (lu) e = 7'b1100010;
        end
        if (e[6] && m_stall < 64'hffff_ffff) m_stall++;
        if ((e[2] | e[1]) && m_flush < 64'hffff_ffff) m_flush++;
    endtask

    initial begin
        int holds;
        logic exm;
        logic [6:0] e;

        vt[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 3'd2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'b1100010, 2'd0, 2'd0};
        vt[1] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 3'd2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0};
        vt[2] = '{5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 3'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'b1100010, 2'd0, 2'd0};
        vt[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0};
        vt[4] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0};
        vt[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 3'd2, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 7'b0000110, 2'd0, 2'd0};
        vt[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 3'd0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 7'b0000000, 2'd1, 2'd1};
        vt[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 7'b0000000, 2'd0, 2'd0};
        vt[8] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd4, 5'd0, 3'd0, 1'b0, 5'd7, 5'd7, 1'b0, 1'b1, 7'b0000000, 2'd2, 2'd0};
        vt[9] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd8, 5'd0, 3'd0, 1'b0, 5'd3, 5'd8, 1'b1, 1'b1, 7'b0000000, 2'd1, 2'd2};

        // outputs forced low while reset is held, even with hazard inputs active
        idle();
        ex_redirect = 1'b1;
        ex_muldiv = 1'b1;
        mem_req = 1'b1;
        #2;
        chk("reset_ctl", ctl, 7'b0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_flush", flush_cnt, 0);
        do_reset();

        // saturating counter boundary
        sat_inc = 1'b1;
        repeat (5) tick();
        chk("sat_mid", sat_cnt, 5);
        repeat (5) tick();
        chk("sat_top", sat_cnt, 7);
        sat_inc = 1'b0;

        // single-cycle vector table, all from RUN
        foreach (vt[i]) begin
            id_rs1 = vt[i].id_rs1; id_rs2 = vt[i].id_rs2;
            id_use_rs1 = vt[i].u1; id_use_rs2 = vt[i].u2;
            ex_rs1 = vt[i].ex_rs1; ex_rs2 = vt[i].ex_rs2; ex_rd = vt[i].ex_rd;
            ex_read_mem = vt[i].rmem; ex_redirect = vt[i].redir;
            mem_rd = vt[i].mem_rd; wb_rd = vt[i].wb_rd;
            mem_write_reg = vt[i].mwr; wb_write_reg = vt[i].wwr;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), ctl, vt[i].ctl);
            chk($sformatf("vec%0d_fwd", i), {fwd1, fwd2}, {vt[i].f1, vt[i].f2});
            tick();
        end

        // load-use: one bubble, then the consumer forwards from WB
        do_reset();
        ex_read_mem = 3'd2; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        @(negedge clk);
        chk("lu_stall", ctl, 7'b1100010);
        tick();
        idle();
        ex_rs1 = 5'd5; wb_rd = 5'd5; wb_write_reg = 1'b1;
        @(negedge clk);
        chk("lu_after_ctl", ctl, 7'b0);
        chk("lu_fwd", fwd1, 2'b10);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_flush_cnt", flush_cnt, 1);

        // redirect: flush for exactly the asserted cycle
        do_reset();
        ex_redirect = 1'b1;
        @(negedge clk);
        chk("redir_ctl", ctl, 7'b0000110);
        tick();
        idle();
        @(negedge clk);
        chk("redir_after", ctl, 7'b0);
        chk("redir_flush_cnt", flush_cnt, 1);
        chk("redir_stall_cnt", stall_cnt, 0);

        // MUL/DIV: op sits in EX through the release cycle
        do_reset();
        holds = 0;
        exm = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ex_muldiv = (c < 4);
            @(negedge clk);
            holds += int'(pc_hold);
            exm |= ex_mem_hold;
            tick();
        end
        chk("md_holds", holds, LAT - 1);
        chk("md_exmem", exm, 0);
        chk("md_stall_cnt", stall_cnt, LAT - 1);
        ex_redirect = 1'b1;
        @(negedge clk);
        chk("md_back_run", ctl, 7'b0000110);
        tick();

        // memory wait with a redirect pending the whole time
        do_reset();
        mem_req = 1'b1; ex_redirect = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("memw_%0d", c), ctl, 7'b1111001);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("memw_release", ctl, 7'b0000110);
        tick();
        idle();
        @(negedge clk);
        chk("memw_after", ctl, 7'b0);
        chk("memw_stall_cnt", stall_cnt, 3);
        chk("memw_flush_cnt", flush_cnt, 1);

        // reset in the middle of a MUL/DIV stall
        do_reset();
        ex_muldiv = 1'b1;
        tick();
        @(negedge clk);
        chk("rmd_busy", pc_hold, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rmd_ctl", ctl, 7'b0);
        chk("rmd_stall_cnt", stall_cnt, 0);
        ex_muldiv = 1'b0;
        ex_redirect = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rmd_run", ctl, 7'b0000110);
        tick();

        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            ex_rs1 = 5'($urandom_range(3)); ex_rs2 = 5'($urandom_range(3));
            ex_rd = 5'($urandom_range(3));
            ex_read_mem = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7));
            ex_redirect = ($urandom_range(6) == 0);
            ex_muldiv = ($urandom_range(9) == 0);
            mem_rd = 5'($urandom_range(3)); wb_rd = 5'($urandom_range(3));
            mem_write_reg = 1'($urandom); wb_write_reg = 1'($urandom);
            mem_req = ($urandom_range(2) == 0); mem_ready = 1'($urandom);
            @(negedge clk);
            model_step(e);
            chk($sformatf("rnd%0d_ctl", i), ctl, e);
            chk($sformatf("rnd%0d_fwd", i), {fwd1, fwd2}, {fwd_model(ex_rs1), fwd_model(ex_rs2)});
            tick();
            chk($sformatf("rnd%0d_cnt", i), {stall_cnt, flush_cnt}, {m_stall[31:0], m_flush[31:0]});
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
